// File: rtl/seg7_pkg.sv
// rtl/seg7_pkg.sv - colour indices, palette, hex decoder and segment boxes for the 7-segment overlay
package seg7_pkg;

  localparam logic [2:0] COL_BG      = 3'd0;
  localparam logic [2:0] COL_GRN_ON  = 3'd1;
  localparam logic [2:0] COL_GRN_OFF = 3'd2;
  localparam logic [2:0] COL_RED_ON  = 3'd3;
  localparam logic [2:0] COL_RED_OFF = 3'd4;
  localparam logic [2:0] COL_SEG_ON  = 3'd5;
  localparam logic [2:0] COL_SEG_OFF = 3'd6;

  localparam logic [11:0] DIGIT_V_MAX = 12'd69;

  typedef struct packed {
    logic [5:0] x_lo;
    logic [5:0] x_hi;
    logic [6:0] v_lo;
    logic [6:0] v_hi;
  } seg_box_t;

  // Inclusive boxes in cell-local coordinates (x 0..63, v 0..69)
  localparam seg_box_t BOX_A  = '{x_lo: 6'd33, x_hi: 6'd55, v_lo: 7'd0,  v_hi: 7'd6};
  localparam seg_box_t BOX_B  = '{x_lo: 6'd57, x_hi: 6'd63, v_lo: 7'd8,  v_hi: 7'd29};
  localparam seg_box_t BOX_C  = '{x_lo: 6'd57, x_hi: 6'd63, v_lo: 7'd38, v_hi: 7'd61};
  localparam seg_box_t BOX_D  = '{x_lo: 6'd33, x_hi: 6'd55, v_lo: 7'd62, v_hi: 7'd69};
  localparam seg_box_t BOX_E  = '{x_lo: 6'd25, x_hi: 6'd31, v_lo: 7'd38, v_hi: 7'd61};
  localparam seg_box_t BOX_F  = '{x_lo: 6'd25, x_hi: 6'd31, v_lo: 7'd8,  v_hi: 7'd29};
  localparam seg_box_t BOX_G  = '{x_lo: 6'd33, x_hi: 6'd55, v_lo: 7'd30, v_hi: 7'd37};
  localparam seg_box_t BOX_DP = '{x_lo: 6'd57, x_hi: 6'd63, v_lo: 7'd64, v_hi: 7'd69};

  function automatic logic in_box(input logic [5:0] x, input logic [6:0] v, input seg_box_t bx);
    return (x >= bx.x_lo) && (x <= bx.x_hi) && (v >= bx.v_lo) && (v <= bx.v_hi);
  endfunction

  // bit0 = a ... bit6 = g
  function automatic logic [6:0] hex_to_seg(input logic [3:0] nib);
    logic [6:0] pat;
    case (nib)
      4'h0: pat = 7'h3F;
      4'h1: pat = 7'h06;
      4'h2: pat = 7'h5B;
      4'h3: pat = 7'h4F;
      4'h4: pat = 7'h66;
      4'h5: pat = 7'h6D;
      4'h6: pat = 7'h7D;
      4'h7: pat = 7'h07;
      4'h8: pat = 7'h7F;
      4'h9: pat = 7'h6F;
      4'hA: pat = 7'h77;
      4'hB: pat = 7'h7C;
      4'hC: pat = 7'h39;
      4'hD: pat = 7'h5E;
      4'hE: pat = 7'h79;
      default: pat = 7'h71;
    endcase
    return pat;
  endfunction

  // Returns {r, g, b}
  function automatic logic [11:0] palette(input logic [2:0] idx);
    logic [11:0] rgb;
    case (idx)
      3'd0: rgb = 12'h111;
      3'd1: rgb = 12'h0F0;
      3'd2: rgb = 12'h030;
      3'd3: rgb = 12'hF00;
      3'd4: rgb = 12'h300;
      3'd5: rgb = 12'hFF0;
      3'd6: rgb = 12'h330;
      default: rgb = 12'h333;
    endcase
    return rgb;
  endfunction

endpackage

// File: rtl/seg7_cell.sv
// rtl/seg7_cell.sv - combinational segment hit test for one digit cell; dp box only with SEG7_DP_EN
module seg7_cell
  import seg7_pkg::*;
(
  input  logic [5:0] x,
  input  logic [6:0] v,
  input  logic [6:0] pattern,
  input  logic       dp,
  output logic       hit,
  output logic       lit
);

  logic [6:0] seg_hit;
  logic       dp_hit;

  assign seg_hit[0] = in_box(x, v, BOX_A);
  assign seg_hit[1] = in_box(x, v, BOX_B);
  assign seg_hit[2] = in_box(x, v, BOX_C);
  assign seg_hit[3] = in_box(x, v, BOX_D);
  assign seg_hit[4] = in_box(x, v, BOX_E);
  assign seg_hit[5] = in_box(x, v, BOX_F);
  assign seg_hit[6] = in_box(x, v, BOX_G);

`ifdef SEG7_DP_EN
  assign dp_hit = in_box(x, v, BOX_DP);
`else
  logic dp_unused;
  assign dp_unused = dp;
  assign dp_hit    = 1'b0;
`endif

  // Boxes are disjoint, so OR-ing the per-box results is exact
  always_comb begin
    hit = (|seg_hit) | dp_hit;
    lit = (|(seg_hit & pattern))
`ifdef SEG7_DP_EN
          | (dp_hit & dp)
`endif
          ;
  end

endmodule

// File: rtl/seg7_led_overlay.sv
// rtl/seg7_led_overlay.sv - LED-row and 7-segment debug overlay, 2-stage pixel pipeline; SEG7_DP_EN enables decimal points
module seg7_led_overlay
  import seg7_pkg::*;
#(
  parameter int NUM_RED_LEDS   = 16,
  parameter int NUM_GREEN_LEDS = 16,
  parameter int NUM_DIGITS     = 6,
  parameter int SCALE_LOG2     = 0,
  parameter int GREEN_Y        = 65,
  parameter int RED_Y          = 97,
  parameter int DIGIT_Y        = 151,
  parameter int BLINK_FRAMES   = 30
) (
  input  logic                      clk_video,
  input  logic                      reset,
  input  logic                      hsync_in,
  input  logic                      vsync_in,
  input  logic                      active_in,
  input  logic [11:0]               pixel_count,
  input  logic [11:0]               line_count,
  input  logic [NUM_RED_LEDS-1:0]   red_leds,
  input  logic [NUM_GREEN_LEDS-1:0] green_leds,
  input  logic [4*NUM_DIGITS-1:0]   segments,
  input  logic [NUM_DIGITS-1:0]     dp,
  input  logic [NUM_DIGITS-1:0]     blink_mask,
  output logic                      hsync,
  output logic                      vsync,
  output logic                      de,
  output logic [3:0]                r,
  output logic [3:0]                g,
  output logic [3:0]                b
);

  localparam int FCW = (BLINK_FRAMES > 1) ? $clog2(BLINK_FRAMES) : 1;
  localparam logic [FCW-1:0] FC_LAST = FCW'(BLINK_FRAMES - 1);

  localparam logic [11:0] GREEN_LO = 12'(GREEN_Y);
  localparam logic [11:0] GREEN_HI = 12'(GREEN_Y + 15);
  localparam logic [11:0] RED_LO   = 12'(RED_Y);
  localparam logic [11:0] RED_HI   = 12'(RED_Y + 15);
  localparam logic [11:0] GREEN_W  = 12'(32 * NUM_GREEN_LEDS);
  localparam logic [11:0] RED_W    = 12'(32 * NUM_RED_LEDS);
  localparam logic [11:0] DIGIT_LO = 12'(DIGIT_Y);

  // Frame-stable copies of the board state
  logic                      vsync_d;
  logic [NUM_RED_LEDS-1:0]   red_sh;
  logic [NUM_GREEN_LEDS-1:0] green_sh;
  logic [4*NUM_DIGITS-1:0]   seg_sh;
  logic [NUM_DIGITS-1:0]     blink_sh;
  logic [FCW-1:0]            frame_cnt;
  logic                      blink_off;
  logic                      vs_rise;

  assign vs_rise = vsync_in & ~vsync_d;

`ifdef SEG7_DP_EN
  logic [NUM_DIGITS-1:0] dp_sh;
`else
  logic dp_unused;
  assign dp_unused = ^dp;
`endif

  always_ff @(posedge clk_video or negedge reset) begin
    if (!reset) begin
      vsync_d   <= 1'b0;
      red_sh    <= '0;
      green_sh  <= '0;
      seg_sh    <= '0;
      blink_sh  <= '0;
      frame_cnt <= '0;
      blink_off <= 1'b0;
`ifdef SEG7_DP_EN
      dp_sh     <= '0;
`endif
    end else begin
      vsync_d <= vsync_in;
      if (vs_rise) begin
        red_sh   <= red_leds;
        green_sh <= green_leds;
        seg_sh   <= segments;
        blink_sh <= blink_mask;
`ifdef SEG7_DP_EN
        dp_sh    <= dp;
`endif
        if (frame_cnt == FC_LAST) begin
          frame_cnt <= '0;
          blink_off <= ~blink_off;
        end else begin
          frame_cnt <= frame_cnt + 1'b1;
        end
      end
    end
  end

  // LED rows: zero-extend to 32 so a 5-bit index always fits
  logic [31:0] green_ext;
  logic [31:0] red_ext;
  logic [6:0]  green_sel;
  logic [6:0]  red_sel;
  logic        in_green;
  logic        in_red;

  assign green_ext = 32'(green_sh);
  assign red_ext   = 32'(red_sh);
  assign green_sel = 7'(NUM_GREEN_LEDS - 1) - pixel_count[11:5];
  assign red_sel   = 7'(NUM_RED_LEDS - 1) - pixel_count[11:5];
  assign in_green  = (line_count >= GREEN_LO) && (line_count <= GREEN_HI) && (pixel_count < GREEN_W);
  assign in_red    = (line_count >= RED_LO) && (line_count <= RED_HI) && (pixel_count < RED_W);

  // Digit row; the subtraction only matters when line_count >= DIGIT_LO
  logic [11:0] u;
  logic [11:0] line_off;
  logic [11:0] v_full;
  logic        digit_valid;
  logic [2:0]  dig_idx;
  logic [31:0] seg_ext;
  logic [7:0]  blink_ext;
  logic [7:0]  dp_ext;
  logic [3:0]  nibble;
  logic        blank;
  logic [6:0]  cell_pattern;
  logic        cell_dp;
  logic        cell_hit;
  logic        cell_lit;

  assign u           = pixel_count >> SCALE_LOG2;
  assign line_off    = line_count - DIGIT_LO;
  assign v_full      = line_off >> SCALE_LOG2;
  assign digit_valid = (line_count >= DIGIT_LO) && (v_full <= DIGIT_V_MAX) && (u[11:6] < 6'(NUM_DIGITS));
  assign dig_idx     = 3'(NUM_DIGITS - 1) - u[8:6];
  assign seg_ext     = 32'(seg_sh);
  assign blink_ext   = 8'(blink_sh);
  assign nibble      = seg_ext[{dig_idx, 2'b00} +: 4];
  assign blank       = blink_ext[dig_idx] & blink_off;

`ifdef SEG7_DP_EN
  assign dp_ext = 8'(dp_sh);
`else
  assign dp_ext = 8'h00;
`endif

  assign cell_pattern = blank ? 7'h00 : hex_to_seg(nibble);
  assign cell_dp      = dp_ext[dig_idx] & ~blank;

  seg7_cell u_cell (
    .x       (u[5:0]),
    .v       (v_full[6:0]),
    .pattern (cell_pattern),
    .dp      (cell_dp),
    .hit     (cell_hit),
    .lit     (cell_lit)
  );

  logic [2:0] col_next;

  always_comb begin
    col_next = COL_BG;
    if (in_green) begin
      if (pixel_count[4]) col_next = green_ext[green_sel[4:0]] ? COL_GRN_ON : COL_GRN_OFF;
    end else if (in_red) begin
      if (pixel_count[4]) col_next = red_ext[red_sel[4:0]] ? COL_RED_ON : COL_RED_OFF;
    end else if (digit_valid && cell_hit) begin
      col_next = cell_lit ? COL_SEG_ON : COL_SEG_OFF;
    end
  end

  logic [2:0] col_s1;
  logic       hs_s1;
  logic       vs_s1;
  logic       de_s1;

  always_ff @(posedge clk_video or negedge reset) begin
    if (!reset) begin
      col_s1    <= COL_BG;
      hs_s1     <= 1'b0;
      vs_s1     <= 1'b0;
      de_s1     <= 1'b0;
      hsync     <= 1'b0;
      vsync     <= 1'b0;
      de        <= 1'b0;
      {r, g, b} <= 12'h000;
    end else begin
      col_s1    <= col_next;
      hs_s1     <= hsync_in;
      vs_s1     <= vsync_in;
      de_s1     <= active_in;
      hsync     <= hs_s1;
      vsync     <= vs_s1;
      de        <= de_s1;
      {r, g, b} <= de_s1 ? palette(col_s1) : 12'h000;
    end
  end

endmodule

// File: tb/tb_seg7_led_overlay.sv
// tb/tb_seg7_led_overlay.sv - randomized scoreboard bench for seg7_led_overlay (model follows SEG7_DP_EN)
module tb_seg7_led_overlay;

  localparam int NR = 16;
  localparam int NG = 16;
  localparam int ND = 6;
  localparam int SC = 0;
  localparam int GY = 65;
  localparam int RY = 97;
  localparam int DY = 151;
  localparam int BF = 2;

  logic          clk_video = 1'b0;
  logic          reset = 1'b0;
  logic          hsync_in = 1'b0, vsync_in = 1'b0, active_in = 1'b0;
  logic [11:0]   pixel_count = '0, line_count = '0;
  logic [NR-1:0] red_leds = '0;
  logic [NG-1:0] green_leds = '0;
  logic [4*ND-1:0] segments = '0;
  logic [ND-1:0] dp = '0, blink_mask = '0;
  logic          hsync, vsync, de;
  logic [3:0]    r, g, b;

  seg7_led_overlay #(
    .NUM_RED_LEDS(NR), .NUM_GREEN_LEDS(NG), .NUM_DIGITS(ND), .SCALE_LOG2(SC),
    .GREEN_Y(GY), .RED_Y(RY), .DIGIT_Y(DY), .BLINK_FRAMES(BF)
  ) dut (
    .clk_video(clk_video), .reset(reset),
    .hsync_in(hsync_in), .vsync_in(vsync_in), .active_in(active_in),
    .pixel_count(pixel_count), .line_count(line_count),
    .red_leds(red_leds), .green_leds(green_leds), .segments(segments),
    .dp(dp), .blink_mask(blink_mask),
    .hsync(hsync), .vsync(vsync), .de(de), .r(r), .g(g), .b(b)
  );

  always #5 clk_video = ~clk_video;

  int n_cmp = 0;
  int n_fail = 0;

  int pal[8]    = '{'h111, 'h0F0, 'h030, 'hF00, 'h300, 'hFF0, 'h330, 'h333};
  int hexpat[16] = '{'h3F, 'h06, 'h5B, 'h4F, 'h66, 'h6D, 'h7D, 'h07,
                     'h7F, 'h6F, 'h77, 'h7C, 'h39, 'h5E, 'h79, 'h71};
  // segments a..g in order, then dp
  int bx0[8] = '{33, 57, 57, 33, 25, 25, 33, 57};
  int bx1[8] = '{55, 63, 63, 55, 31, 31, 55, 63};
  int bv0[8] = '{0, 8, 38, 62, 38, 8, 30, 64};
  int bv1[8] = '{6, 29, 61, 69, 61, 29, 37, 69};

  // Staging values the stimulus edits; copied onto the ports with each sample
  logic [NR-1:0]   s_red = '0;
  logic [NG-1:0]   s_green = '0;
  logic [4*ND-1:0] s_seg = '0;
  logic [ND-1:0]   s_dp = '0, s_blink = '0;

  // Reference state: what the display should currently be showing
  logic [NR-1:0]   m_red;
  logic [NG-1:0]   m_green;
  logic [4*ND-1:0] m_seg;
  logic [ND-1:0]   m_dp, m_blink;
  int              m_frames;
  logic            m_prev_vs;

  logic [14:0] exp_q[$];
  logic        issue = 1'b0;
  logic        d1, d2;

  function automatic int model_col(input int pix, input int line);
    int u, v, d, x, nib;
    bit on;
    if (line >= GY && line < GY + 16 && pix < 32 * NG)
      return (pix % 32 >= 16) ? (m_green[NG - 1 - pix / 32] ? 1 : 2) : 0;
    if (line >= RY && line < RY + 16 && pix < 32 * NR)
      return (pix % 32 >= 16) ? (m_red[NR - 1 - pix / 32] ? 3 : 4) : 0;
    if (line >= DY) begin
      u = pix / (1 << SC);
      v = (line - DY) / (1 << SC);
      if (v <= 69 && u / 64 < ND) begin
        d   = ND - 1 - u / 64;
        x   = u % 64;
        on  = !(m_blink[d] && ((m_frames / BF) % 2 == 1));
        nib = int'((m_seg >> (4 * d)) & 'hF);
        for (int k = 0; k < 7; k++)
          if (x >= bx0[k] && x <= bx1[k] && v >= bv0[k] && v <= bv1[k])
            return (on && hexpat[nib][k]) ? 5 : 6;
`ifdef SEG7_DP_EN
        if (x >= bx0[7] && x <= bx1[7] && v >= bv0[7] && v <= bv1[7])
          return (on && m_dp[d]) ? 5 : 6;
`endif
      end
    end
    return 0;
  endfunction

  task automatic model_reset();
    m_red = '0; m_green = '0; m_seg = '0; m_dp = '0; m_blink = '0;
    m_frames = 0; m_prev_vs = 1'b0;
  endtask

  // One pixel per clock: drive, predict, then let the model see the same edge
  task automatic drive(input int pix, input int line, input bit hs, input bit vs, input bit act);
    int col;
    logic [11:0] rgb;
    @(posedge clk_video);
    #1;
    pixel_count = 12'(pix); line_count = 12'(line);
    hsync_in = hs; vsync_in = vs; active_in = act;
    red_leds = s_red; green_leds = s_green; segments = s_seg; dp = s_dp; blink_mask = s_blink;
    col = model_col(pix, line);
    rgb = act ? 12'(pal[col]) : 12'h000;
    exp_q.push_back({hs, vs, act, rgb});
    issue = 1'b1;
    if (vs && !m_prev_vs) begin
      m_red = s_red; m_green = s_green; m_seg = s_seg; m_dp = s_dp; m_blink = s_blink;
      m_frames++;
    end
    m_prev_vs = vs;
  endtask

  task automatic drive_rand();
    int pix, line;
    case ($urandom % 5)
      0: begin line = GY + $urandom % 16; pix = $urandom % (32 * NG + 40); end
      1: begin line = RY + $urandom % 16; pix = $urandom % (32 * NR + 40); end
      2, 3: begin line = DY - 2 + $urandom % 76; pix = $urandom % (64 * ND + 40); end
      default: begin line = $urandom % 1024; pix = $urandom % 1024; end
    endcase
    drive(pix, line, 1'($urandom), 1'b0, ($urandom % 8) != 0);
  endtask

  task automatic check_zero(input string name);
    n_cmp++;
    if ({hsync, vsync, de, r, g, b} !== 15'h0) begin
      n_fail++;
      $display("FAIL %s: got %h want 0000 at %0t", name, {hsync, vsync, de, r, g, b}, $time);
    end
  endtask

  task automatic do_reset();
    @(posedge clk_video);
    #3;
    reset = 1'b0;
    issue = 1'b0;
    exp_q.delete();
    hsync_in = 1'b1; active_in = 1'b1; vsync_in = 1'b0;
    #1;
    check_zero("reset_async");
    repeat (5) @(posedge clk_video);
    @(negedge clk_video);
    check_zero("reset_hold");
    model_reset();
    reset = 1'b1;
  endtask

  task automatic new_frame();
    s_red = NR'($urandom); s_green = NG'($urandom); s_seg = (4*ND)'($urandom);
    s_dp = ND'($urandom); s_blink = ND'($urandom);
    drive($urandom % 800, 500, 1'b0, 1'b1, 1'b0);
    drive($urandom % 800, 501, 1'b0, 1'b1, 1'b0);
  endtask

  always @(posedge clk_video or negedge reset) begin
    if (!reset) begin
      d1 <= 1'b0;
      d2 <= 1'b0;
    end else begin
      d1 <= issue;
      d2 <= d1;
    end
  end

  always @(negedge clk_video) begin
    logic [14:0] want;
    if (reset && d2) begin
      n_cmp++;
      if (exp_q.size() == 0) begin
        n_fail++;
        $display("FAIL pixel: output %h with no expectation queued", {hsync, vsync, de, r, g, b});
      end else begin
        want = exp_q.pop_front();
        if ({hsync, vsync, de, r, g, b} !== want) begin
          n_fail++;
          $display("FAIL pixel: got hs/vs/de/rgb %h want %h at %0t", {hsync, vsync, de, r, g, b}, want, $time);
        end
      end
    end
  end

  initial begin
    model_reset();
    repeat (3) @(posedge clk_video);
    do_reset();

    // No vsync yet: shadows still clear
    repeat (150) drive_rand();

    for (int f = 0; f < 14; f++) begin
      if (f == 7) begin
        do_reset();
        repeat (40) drive_rand();
      end
      new_frame();
      if (f == 0) begin
        // Directed frame: load fixed values, then scramble the inputs mid-frame
        s_green = NG'('h8001); s_seg = (4*ND)'('h000008); s_dp = ND'(1); s_blink = ND'(1);
        drive(0, 600, 1'b0, 1'b0, 1'b0);
        drive(0, 600, 1'b0, 1'b1, 1'b0);
        s_green = '0; s_seg = (4*ND)'($urandom); s_dp = '0;
        for (int p = 0; p < 32; p++) drive(p, 70, 1'b0, 1'b0, 1'b1);
        for (int p = 480; p < 512; p += 4) drive(p, 70, 1'b0, 1'b0, 1'b1);
        drive(360, DY + 33, 1'b0, 1'b0, 1'b1);
        drive(380, DY + 66, 1'b0, 1'b0, 1'b1);
        drive(296, DY + 33, 1'b0, 1'b0, 1'b1);
        drive(0, 0, 1'b0, 1'b0, 1'b0);
        drive(0, 0, 1'b0, 1'b0, 1'b1);
      end else begin
        s_red = NR'($urandom); s_green = NG'($urandom); s_seg = (4*ND)'($urandom);
        s_dp = ND'($urandom); s_blink = ND'($urandom);
      end
      for (int k = 0; k < 6; k++) drive(360, DY + 33, 1'b0, 1'b0, 1'b1);
      repeat (250) drive_rand();
    end

    @(posedge clk_video);
    #1;
    issue = 1'b0;
    repeat (4) @(posedge clk_video);
    @(negedge clk_video);
    n_cmp++;
    if (exp_q.size() != 0) begin
      n_fail++;
      $display("FAIL drain: %0d expectations left, want 0", exp_q.size());
    end
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule
